redstone_tick_driver: RTL



---
 rtl/redstone_pkg.sv | 17 +
 rtl/redstone_tick_phase.sv | 39 +++
 rtl/redstone_tick_driver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/redstone_pkg.sv
// Shared state encoding and default sizing for the redstone tick driver.
package redstone_pkg;

    localparam int DEF_NUM_INPUTS  = 9;
    localparam int DEF_NUM_OUTPUTS = 8;
    localparam int DEF_TICK_DIV    = 4;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        TICK_HI = 3'd2,
        TICK_LO = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/redstone_tick_phase.sv
// Phase counter within one tick period: runs 0..TICK_DIV-1 while enabled,
// held at 0 otherwise, and flags the final phase of the period.
module redstone_tick_phase
    import redstone_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_last
);

    localparam int PH_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(TICK_DIV - 1);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;

    assign o_last = (phase_q == PH_LAST);

    always_comb begin
        phase_d = phase_q;
        if (!i_run || o_last) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/redstone_tick_driver.sv
// Drives a compiled redstone block: applies a stimulus, issues a requested
// number of torch-clock ticks, then captures the block outputs.
module redstone_tick_driver
    import redstone_pkg::*;
#(
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int CNT_W       = DEF_CNT_W,
    localparam int OUT_W      = NUM_OUTPUTS + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [CNT_W-1:0]      i_ticks,
    input  logic [NUM_INPUTS-1:0] i_in_data,
    input  logic                  i_abort,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [OUT_W-1:0]      o_out_data,
    output logic                  o_tick,
    output logic [NUM_INPUTS-1:0] o_rs_inputs,
    input  logic [OUT_W-1:0]      i_rs_outputs,
    output logic [CNT_W-1:0]      o_tick_total
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [CNT_W-1:0]      total_q, total_d;
    logic [NUM_INPUTS-1:0] rs_in_q, rs_in_d;
    logic [OUT_W-1:0]      out_q, out_d;
    logic                  tick_q, tick_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  phase_run;
    logic                  phase_last;

    assign phase_run = (state_q == TICK_HI) || (state_q == TICK_LO);

    redstone_tick_phase #(
        .TICK_DIV (TICK_DIV)
    ) u_phase (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_run   (phase_run),
        .o_last  (phase_last)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        total_d = total_q;
        rs_in_d = rs_in_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    rs_in_d = i_in_data;
                    rem_d   = i_ticks;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (rem_q != '0) begin
                    state_d = TICK_HI;
                end else begin
                    out_d   = i_rs_outputs;
                    state_d = DONE;
                end
            end
            TICK_HI: begin
                // The tick is already on the wire, so it counts even if aborted now.
                rem_d   = rem_q - CNT_W'(1);
                total_d = total_q + CNT_W'(1);
                state_d = i_abort ? IDLE : TICK_LO;
            end
            TICK_LO: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (phase_last) begin
                    if (rem_q == '0) begin
                        out_d   = i_rs_outputs;
                        state_d = DONE;
                    end else begin
                        state_d = TICK_HI;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave flops glitch-free.
        tick_d  = (state_d == TICK_HI);
        done_d  = (state_d == DONE);
        busy_d  = (state_d == SETUP) || (state_d == TICK_HI) || (state_d == TICK_LO);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            total_q <= '0;
            rs_in_q <= '0;
            out_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            total_q <= total_d;
            rs_in_q <= rs_in_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_out_data   = out_q;
    assign o_tick       = tick_q;
    assign o_rs_inputs  = rs_in_q;
    assign o_tick_total = total_q;

endmodule
